// File: rtl/crc32_stream.sv
// ---------------------------------------------------------------------------
// crc32_stream
//
// Streaming Ethernet CRC-32 generator/checker. Frame data arrives P_BYTES
// bytes per beat over a valid/ready handshake with a per-byte keep mask.
// Once per frame it presents the FCS to append, a residue pass/fail flag and
// the frame length. It also keeps saturating good/bad frame counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_data/s_keep       beat data (byte 0 = [7:0] = first on wire), byte mask
//   s_valid/s_last      beat valid, final beat of frame
//   s_ready             block can accept a beat (low while a result is held)
//   res_valid/res_ready result handshake
//   res_fcs             FCS of frame, [7:0] = first byte to transmit
//   res_ok              residue matched and frame is at least 4 bytes long
//   res_len             bytes processed in frame, saturating at 16'hFFFF
//   clr_cnt             synchronous clear of both counters
//   cnt_good/cnt_bad    saturating counts of passing / failing frames
// ---------------------------------------------------------------------------
module crc32_stream #(
   parameter int          P_BYTES   = 4,
   parameter logic [31:0] P_POLY    = 32'h04C11DB7,
   parameter logic [31:0] P_INIT    = 32'hFFFFFFFF,
   parameter logic [31:0] P_RESIDUE = 32'hC704DD7B,
   parameter int          P_CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [8*P_BYTES-1:0]   s_data,
   input  logic [P_BYTES-1:0]     s_keep,
   input  logic                   s_valid,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [31:0]            res_fcs,
   output logic                   res_ok,
   output logic [15:0]            res_len,
   input  logic                   clr_cnt,
   output logic [P_CNT_W-1:0]     cnt_good,
   output logic [P_CNT_W-1:0]     cnt_bad
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BODY   = 2'd1,
      RESULT = 2'd2
   } state_t;

   state_t               state_q;
   logic [31:0]          crc_q;
   logic [31:0]          crc_d;
   logic [15:0]          len_q;
   logic [15:0]          len_d;
   logic                 resValid_q;
   logic [31:0]          resFcs_q;
   logic                 resOk_q;
   logic [15:0]          resLen_q;
   logic [P_CNT_W-1:0]   cntGood_q;
   logic [P_CNT_W-1:0]   cntBad_q;
   logic                 beatAccept;
   logic [16:0]          lenSum;

   // One byte through the CRC register. The register is kept in normal
   // (MSB-first) orientation while data bits enter LSB-first, the same order
   // they appear on MII, so the stock polynomial can be used unreflected.
   function automatic logic [31:0] crcByte(input logic [31:0] crcIn,
                                           input logic [7:0]  dataIn);
      logic [31:0] c;
      logic        fb;
      c = crcIn;
      for (int b = 0; b < 8; b++) begin
         fb = c[31] ^ dataIn[b];
         c  = {c[30:0], 1'b0};
         if (fb) begin
            c = c ^ P_POLY;
         end
      end
      return c;
   endfunction

   // The register is bit-reversed and inverted to form the FCS, so that
   // res_fcs[7:0] is the first byte on the wire and goes out LSB-first.
   function automatic logic [31:0] fcsOf(input logic [31:0] c);
      logic [31:0] f;
      for (int i = 0; i < 32; i++) begin
         f[i] = ~c[31-i];
      end
      return f;
   endfunction

   // The upstream may only present a beat while no result is held; ready
   // depends on state alone so it never loops back through s_valid.
   assign s_ready    = (state_q != RESULT);
   assign beatAccept = s_valid && s_ready;

   // Combinational chain of P_BYTES single-byte stages. Bytes whose keep bit
   // is clear pass the register through untouched, so any keep pattern works.
   // Length grows by the number of kept bytes and saturates at all-ones.
   always_comb begin
      crc_d  = crc_q;
      lenSum = {1'b0, len_q};
      for (int i = 0; i < P_BYTES; i++) begin
         if (s_keep[i]) begin
            crc_d  = crcByte(crc_d, s_data[8*i +: 8]);
            lenSum = lenSum + 17'd1;
         end
      end
      len_d = lenSum[16] ? 16'hFFFF : lenSum[15:0];
   end

   // Frame FSM. Results are captured from the post-update register on the
   // beat that carries s_last, so res_valid rises the following cycle and
   // stays stable until the downstream takes it. Leaving RESULT re-arms the
   // register for the next frame, which costs at most one bubble cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         crc_q      <= P_INIT;
         len_q      <= '0;
         resValid_q <= 1'b0;
         resFcs_q   <= '0;
         resOk_q    <= 1'b0;
         resLen_q   <= '0;
      end else begin
         case (state_q)
            IDLE, BODY: begin
               if (beatAccept) begin
                  crc_q <= crc_d;
                  len_q <= len_d;
                  if (s_last) begin
                     state_q    <= RESULT;
                     resValid_q <= 1'b1;
                     resFcs_q   <= fcsOf(crc_d);
                     resOk_q    <= (crc_d == P_RESIDUE) && (len_d >= 16'd4);
                     resLen_q   <= len_d;
                  end else begin
                     state_q <= BODY;
                  end
               end
            end
            RESULT: begin
               if (res_ready) begin
                  state_q    <= IDLE;
                  resValid_q <= 1'b0;
                  crc_q      <= P_INIT;
                  len_q      <= '0;
               end
            end
            default: begin
               state_q    <= IDLE;
               resValid_q <= 1'b0;
               crc_q      <= P_INIT;
               len_q      <= '0;
            end
         endcase
      end
   end

   // Frame counters step once as a result leaves (valid and ready together).
   // A clear on the same cycle wins over the increment; both hold at all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         cntGood_q <= '0;
         cntBad_q  <= '0;
      end else if (resValid_q && res_ready) begin
         if (resOk_q) begin
            if (cntGood_q != {P_CNT_W{1'b1}}) begin
               cntGood_q <= cntGood_q + 1'b1;
            end
         end else begin
            if (cntBad_q != {P_CNT_W{1'b1}}) begin
               cntBad_q <= cntBad_q + 1'b1;
            end
         end
      end
   end

   assign res_valid = resValid_q;
   assign res_fcs   = resFcs_q;
   assign res_ok    = resOk_q;
   assign res_len   = resLen_q;
   assign cnt_good  = cntGood_q;
   assign cnt_bad   = cntBad_q;

endmodule
